// File: rtl/mreg.sv
// mreg: memory-access stage; registers execute results, runs the LW/SW data-memory handshake, stalls until it completes.
// Ports: clk, resetn (sync, active-low); e_* execute-stage results; M_bubble clears the stage register;
//        dresp_* memory response; dreq_* memory request; m_stall freezes upstream and this stage;
//        m_pc/m_icode/m_dst/m_val go to write-back.
module mreg (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] e_pc,
    input  logic [31:0] e_val3,
    input  logic [31:0] e_valt,
    input  logic [5:0]  e_icode,
    input  logic [5:0]  e_acode,
    input  logic [4:0]  e_dst,
    input  logic [3:0]  e_req,
    input  logic        e_vreq,
    input  logic        M_bubble,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    output logic        m_stall,
    output logic [31:0] m_pc,
    output logic [5:0]  m_icode,
    output logic [4:0]  m_dst,
    output logic [31:0] m_val
);
    localparam logic [5:0] LW = 6'h23;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state, state_n;
    logic [31:0] m_val3, m_valt;
    logic [5:0] m_acode;
    logic [3:0] m_req;
    logic m_vreq, done;
    // funct code travels with the instruction but no consumer in this stage reads it
    logic unused_acode;
    assign unused_acode = ^m_acode;
    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (!resetn)
            {m_pc, m_val3, m_valt, m_icode, m_acode, m_dst, m_req, m_vreq} <= '0;
        else if (!m_stall)
            {m_pc, m_val3, m_valt, m_icode, m_acode, m_dst, m_req, m_vreq} <= M_bubble ? '0 :
                {e_pc, e_val3, e_valt, e_icode, e_acode, e_dst, e_req, e_vreq};
    end
    // once the address is accepted (DATA) only data_ok matters; before that both must arrive together
    always_comb begin
        state_n = state;
        done = 1'b0;
        if (m_vreq) begin
            done = (state == DATA) ? dresp_data_ok : dresp_addr_ok & dresp_data_ok;
            state_n = done ? IDLE : (state == DATA || dresp_addr_ok) ? DATA : ADDR;
        end
    end
    assign dreq_valid  = m_vreq & (state != DATA);
    assign dreq_addr   = m_val3;
    assign dreq_strobe = m_req;
    assign dreq_data   = m_valt;
    assign m_stall     = m_vreq & ~done;
    assign m_val       = (m_icode == LW) ? dresp_data : m_val3;
endmodule

// File: tb/tb_mreg.sv
// tb_mreg: directed and randomized checks of mreg against a transaction-level reference model.
module tb_mreg;
    localparam logic [5:0] LW = 6'h23, SW = 6'h2b, ADDIU = 6'h09;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [31:0] e_pc = '0, e_val3 = '0, e_valt = '0, dresp_data = '0;
    logic [5:0] e_icode = '0, e_acode = '0;
    logic [4:0] e_dst = '0;
    logic [3:0] e_req = '0;
    logic e_vreq = 1'b0, M_bubble = 1'b0, dresp_addr_ok = 1'b0, dresp_data_ok = 1'b0;
    logic dreq_valid, m_stall;
    logic [31:0] dreq_addr, dreq_data, m_pc, m_val;
    logic [3:0] dreq_strobe;
    logic [5:0] m_icode;
    logic [4:0] m_dst;
    mreg dut (
        .clk(clk), .resetn(resetn), .e_pc(e_pc), .e_val3(e_val3), .e_valt(e_valt),
        .e_icode(e_icode), .e_acode(e_acode), .e_dst(e_dst), .e_req(e_req), .e_vreq(e_vreq),
        .M_bubble(M_bubble), .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .m_stall(m_stall), .m_pc(m_pc),
        .m_icode(m_icode), .m_dst(m_dst), .m_val(m_val)
    );
    always #5 clk = ~clk;
    // reference model: the instruction held in the stage and whether its address was already accepted
    logic [31:0] r_pc = '0, r_val3 = '0, r_valt = '0;
    logic [5:0] r_icode = '0;
    logic [4:0] r_dst = '0;
    logic [3:0] r_req = '0;
    logic r_vreq = 1'b0, accepted = 1'b0;
    int n_chk = 0, n_fail = 0, issues = 0;
    logic [31:0] last_addr = '0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic set_e(input logic [5:0] ic, input logic [31:0] pc, input logic [31:0] v3,
                         input logic [31:0] vt, input logic [4:0] d);
        e_icode = ic;
        e_pc = pc;
        e_val3 = v3;
        e_valt = vt;
        e_dst = d;
        e_acode = 6'($urandom);
        e_vreq = (ic == LW) || (ic == SW);
        e_req = (ic == SW) ? 4'hf : 4'h0;
    endtask
    task automatic model_clear();
        {r_pc, r_val3, r_valt, r_icode, r_dst, r_req, r_vreq, accepted} = '0;
    endtask
    // check all outputs mid-cycle, then advance one clock and update the model
    task automatic step();
        logic complete;
        @(negedge clk);
        complete = r_vreq && (accepted ? dresp_data_ok : (dresp_addr_ok && dresp_data_ok));
        chk("dreq_valid", 32'(dreq_valid), 32'(r_vreq && !accepted));
        chk("dreq_addr", dreq_addr, r_val3);
        chk("dreq_strobe", 32'(dreq_strobe), 32'(r_req));
        chk("dreq_data", dreq_data, r_valt);
        chk("m_stall", 32'(m_stall), 32'(r_vreq && !complete));
        chk("m_pc", m_pc, r_pc);
        chk("m_icode", 32'(m_icode), 32'(r_icode));
        chk("m_dst", 32'(m_dst), 32'(r_dst));
        chk("m_val", m_val, (r_icode == LW) ? dresp_data : r_val3);
        if (dreq_valid && dresp_addr_ok) begin
            issues++;
            last_addr = dreq_addr;
        end
        @(posedge clk);
        if (!resetn) model_clear();
        else if (r_vreq && !complete) accepted = accepted || dresp_addr_ok;
        else begin
            accepted = 1'b0;
            if (M_bubble) model_clear();
            else {r_pc, r_val3, r_valt, r_icode, r_dst, r_req, r_vreq} =
                {e_pc, e_val3, e_valt, e_icode, e_dst, e_req, e_vreq};
        end
        #1;
    endtask
    initial begin
        @(posedge clk);
        model_clear();
        #1;
        step();
        resetn = 1'b1;
        // ALU instruction: no stall, result visible right after the edge
        set_e(ADDIU, 32'h100, 32'h5, 32'h0, 5'd3);
        step();
        set_e(6'h0, 32'h0, 32'h0, 32'h0, 5'd0);
        chk("addiu_val", m_val, 32'h5);
        chk("addiu_dst", 32'(m_dst), 32'd3);
        chk("addiu_stall", 32'(m_stall), 32'd0);
        chk("addiu_valid", 32'(dreq_valid), 32'd0);
        // LW: addr_ok on cycle 2, data_ok on cycle 4
        set_e(LW, 32'h200, 32'h8000_0010, 32'h0, 5'd7);
        step();
        set_e(6'h0, 32'h0, 32'h0, 32'h0, 5'd0);
        #1 chk("lw_c1_valid", 32'(dreq_valid), 32'd1);
        chk("lw_c1_stall", 32'(m_stall), 32'd1);
        step();
        dresp_addr_ok = 1'b1;
        #1 chk("lw_c2_addr", dreq_addr, 32'h8000_0010);
        chk("lw_c2_valid", 32'(dreq_valid), 32'd1);
        step();
        dresp_addr_ok = 1'b0;
        #1 chk("lw_c3_valid", 32'(dreq_valid), 32'd0);
        chk("lw_c3_stall", 32'(m_stall), 32'd1);
        step();
        dresp_data_ok = 1'b1;
        dresp_data = 32'hDEAD_BEEF;
        #1 chk("lw_c4_stall", 32'(m_stall), 32'd0);
        chk("lw_c4_val", m_val, 32'hDEAD_BEEF);
        step();
        dresp_data_ok = 1'b0;
        // SW completing in its first cycle
        set_e(SW, 32'h300, 32'h20, 32'h1234_5678, 5'd0);
        step();
        set_e(ADDIU, 32'h304, 32'h9, 32'h0, 5'd4);
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        #1 chk("sw_strobe", 32'(dreq_strobe), 32'hf);
        chk("sw_data", dreq_data, 32'h1234_5678);
        chk("sw_stall", 32'(m_stall), 32'd0);
        step();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        #1 chk("sw_next_pc", m_pc, 32'h304);
        // reset while waiting in ADDR, then a stray data_ok
        set_e(LW, 32'h400, 32'h44, 32'h0, 5'd5);
        step();
        set_e(6'h0, 32'h0, 32'h0, 32'h0, 5'd0);
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        #1 chk("rst_valid", 32'(dreq_valid), 32'd0);
        chk("rst_pc", m_pc, 32'h0);
        dresp_data_ok = 1'b1;
        dresp_data = 32'hFFFF_FFFF;
        step();
        dresp_data_ok = 1'b0;
        #1 chk("late_ok_pc", m_pc, 32'h0);
        chk("late_ok_val", m_val, 32'h0);
        // bubble during a stalled load, then in a free cycle
        set_e(LW, 32'h500, 32'h50, 32'h0, 5'd6);
        step();
        M_bubble = 1'b1;
        step();
        #1 chk("bub_hold_pc", m_pc, 32'h500);
        chk("bub_hold_icode", 32'(m_icode), 32'(LW));
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        step();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        #1 chk("bub_icode", 32'(m_icode), 32'd0);
        chk("bub_dst", 32'(m_dst), 32'd0);
        chk("bub_val", m_val, 32'h0);
        M_bubble = 1'b0;
        // back-to-back loads
        issues = 0;
        set_e(LW, 32'h600, 32'hA0, 32'h0, 5'd8);
        step();
        set_e(LW, 32'h604, 32'hB0, 32'h0, 5'd9);
        dresp_addr_ok = 1'b1;
        step();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b1;
        dresp_data = 32'h1111_1111;
        #1 chk("b2b_first_addr", dreq_addr, 32'hA0);
        step();
        set_e(6'h0, 32'h0, 32'h0, 32'h0, 5'd0);
        dresp_data_ok = 1'b0;
        dresp_addr_ok = 1'b1;
        #1 chk("b2b_second_addr", dreq_addr, 32'hB0);
        step();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b1;
        step();
        dresp_data_ok = 1'b0;
        chk("b2b_issues", 32'(issues), 32'd2);
        chk("b2b_last_addr", last_addr, 32'hB0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(3))
                0: set_e(LW, $urandom, $urandom, $urandom, 5'($urandom));
                1: set_e(SW, $urandom, $urandom, $urandom, 5'($urandom));
                2: set_e(ADDIU, $urandom, $urandom, $urandom, 5'($urandom));
                default: set_e(6'h0, $urandom, $urandom, $urandom, 5'($urandom));
            endcase
            M_bubble = ($urandom_range(9) == 0);
            resetn = ($urandom_range(31) != 0);
            dresp_addr_ok = 1'($urandom);
            dresp_data_ok = 1'($urandom);
            dresp_data = $urandom;
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
